mem_responder: RTL and testbench

MEM_RESPONDER -- requirements
Module: mem_responder

---
 rtl/mem_pkg.sv | 25 ++
 rtl/ram_sp.sv | 42 ++++
 rtl/mem_responder.sv | 162 ++++++++++++++++
 tb/tb_mem_responder.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// -----------------------------------------------------------------------------
// mem_pkg
// Shared definitions for the memory responder: request codes carried on
// mem_cmd, the fixed addresses of the LED and switch registers, and the
// responder FSM state type.
// -----------------------------------------------------------------------------
package mem_pkg;

  // Request codes on mem_cmd; 2'b11 is not a legal request.
  localparam logic [1:0] MNONE    = 2'b00;
  localparam logic [1:0] MREAD    = 2'b01;
  localparam logic [1:0] MWRITE   = 2'b10;
  localparam logic [1:0] MILLEGAL = 2'b11;

  // Memory-mapped peripheral word addresses.
  localparam int unsigned LED_ADDR = 32'h0000_0100;
  localparam int unsigned SW_ADDR  = 32'h0000_0140;

  // Responder FSM: waiting for a request, or signalling completion.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RESP = 1'b1
  } state_e;

endpackage : mem_pkg

// File: rtl/ram_sp.sv
// -----------------------------------------------------------------------------
// ram_sp
// Single-port RAM, DEPTH x DATA_W, synchronous write and registered read.
// Contents are not reset.
//
// Ports:
//   clk_i    - clock, rising edge
//   we_i     - write enable: mem[addr_i] <= wdata_i
//   re_i     - read enable: rdata_o <= mem[addr_i]; rdata_o holds otherwise
//   addr_i   - word address
//   wdata_i  - write data
//   rdata_o  - registered read data
// -----------------------------------------------------------------------------
module ram_sp #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 256,
  parameter int AW     = 8
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic              re_i,
  input  logic [AW-1:0]     addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  // Storage array write port and registered read port.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
    if (re_i) begin
      rdata_q <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule : ram_sp

// File: rtl/mem_responder.sv
// -----------------------------------------------------------------------------
// mem_responder
// Single-outstanding memory responder. A READ or WRITE seen in IDLE is
// accepted on the rising edge and completed one cycle later with a one-cycle
// mem_rdy strobe. The address space holds a RAM at 0..RAM_DEPTH-1, a
// write-only LED register at 0x100 and read-only switches at 0x140. Illegal
// commands and accesses to anything else set a sticky err flag.
//
// Ports:
//   clk        - clock, rising edge
//   reset      - asynchronous active-low reset
//   mem_cmd    - request code (NONE/READ/WRITE/illegal)
//   mem_addr   - word address of the request
//   write_data - store data for a WRITE
//   read_data  - load data; valid in RESP, held until the next READ completes
//   mem_rdy    - one-cycle completion strobe
//   SW         - board switches (read at 0x140)
//   LEDR       - board LEDs (written at 0x100)
//   err        - sticky error flag
// -----------------------------------------------------------------------------
module mem_responder
  import mem_pkg::*;
#(
  parameter int DATA_W    = 16,
  parameter int ADDR_W    = 9,
  parameter int RAM_DEPTH = 256
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        mem_cmd,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] write_data,
  output logic [DATA_W-1:0] read_data,
  output logic              mem_rdy,
  input  logic [7:0]        SW,
  output logic [7:0]        LEDR,
  output logic              err
);

  localparam int RAM_AW = $clog2(RAM_DEPTH);

  // One extra bit so RAM_DEPTH itself is representable in the bound.
  localparam logic [ADDR_W:0]   RAM_TOP = (ADDR_W + 1)'(RAM_DEPTH);
  localparam logic [ADDR_W-1:0] LED_A   = ADDR_W'(LED_ADDR);
  localparam logic [ADDR_W-1:0] SW_A    = ADDR_W'(SW_ADDR);

  state_e            state_q;
  logic              mem_rdy_q;
  logic              ram_sel_q;
  logic [DATA_W-1:0] read_hold_q;
  logic [7:0]        ledr_q;
  logic [7:0]        ledr_d;
  logic              err_q;
  logic              err_d;

  logic              hit_ram_s;
  logic              hit_led_s;
  logic              hit_sw_s;
  logic              is_rd_s;
  logic              is_wr_s;
  logic              is_ill_s;
  logic              bad_s;
  logic              ram_we_s;
  logic              ram_re_s;
  logic [DATA_W-1:0] ram_rdata_s;
  logic [DATA_W-1:0] sw_ext_s;

  // Full-width address decode (no aliasing) and request qualification in IDLE.
  always_comb begin
    hit_ram_s = ({1'b0, mem_addr} < RAM_TOP);
    hit_led_s = (mem_addr == LED_A);
    hit_sw_s  = (mem_addr == SW_A);
    is_rd_s   = (state_q == ST_IDLE) && (mem_cmd == MREAD);
    is_wr_s   = (state_q == ST_IDLE) && (mem_cmd == MWRITE);
    is_ill_s  = (state_q == ST_IDLE) && (mem_cmd == MILLEGAL);
    // Reads may target RAM or SW; writes may target RAM or LEDR.
    bad_s     = is_ill_s
              || (is_rd_s && !(hit_ram_s || hit_sw_s))
              || (is_wr_s && !(hit_ram_s || hit_led_s));
    // Gating with reset keeps a write whose edge falls inside reset from
    // reaching the (unreset) RAM array.
    ram_we_s  = is_wr_s && hit_ram_s && reset;
    ram_re_s  = is_rd_s && hit_ram_s;
    sw_ext_s  = {{(DATA_W-8){1'b0}}, SW};
  end

  // Next values for the LED register and the sticky error flag.
  always_comb begin
    err_d = err_q | bad_s;
    if (is_wr_s && hit_led_s) begin
      ledr_d = write_data[7:0];
    end else begin
      ledr_d = ledr_q;
    end
  end

  ram_sp #(
    .DATA_W (DATA_W),
    .DEPTH  (RAM_DEPTH),
    .AW     (RAM_AW)
  ) u_ram (
    .clk_i   (clk),
    .we_i    (ram_we_s),
    .re_i    (ram_re_s),
    .addr_i  (mem_addr[RAM_AW-1:0]),
    .wdata_i (write_data),
    .rdata_o (ram_rdata_s)
  );

  // Responder FSM with its registered outputs, LED and error registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      mem_rdy_q   <= 1'b0;
      ram_sel_q   <= 1'b0;
      read_hold_q <= {DATA_W{1'b0}};
      ledr_q      <= 8'h00;
      err_q       <= 1'b0;
    end else begin
      ledr_q <= ledr_d;
      err_q  <= err_d;
      case (state_q)
        ST_IDLE: begin
          if (is_rd_s || is_wr_s) begin
            state_q   <= ST_RESP;
            mem_rdy_q <= 1'b1;
            ram_sel_q <= is_rd_s && hit_ram_s;
            // Non-RAM read data is known now; RAM data arrives from the
            // registered read port during RESP.
            if (is_rd_s && !hit_ram_s) begin
              read_hold_q <= hit_sw_s ? sw_ext_s : {DATA_W{1'b0}};
            end
          end else begin
            mem_rdy_q <= 1'b0;
            ram_sel_q <= 1'b0;
          end
        end
        ST_RESP: begin
          state_q   <= ST_IDLE;
          mem_rdy_q <= 1'b0;
          ram_sel_q <= 1'b0;
          // Capture RAM data so it keeps showing after RESP ends.
          if (ram_sel_q) begin
            read_hold_q <= ram_rdata_s;
          end
        end
        default: begin
          state_q   <= ST_IDLE;
          mem_rdy_q <= 1'b0;
          ram_sel_q <= 1'b0;
        end
      endcase
    end
  end

  // During a RAM read's RESP cycle the RAM output register drives directly.
  assign read_data = ram_sel_q ? ram_rdata_s : read_hold_q;
  assign mem_rdy   = mem_rdy_q;
  assign LEDR      = ledr_q;
  assign err       = err_q;

endmodule : mem_responder

// File: tb/tb_mem_responder.sv
// -----------------------------------------------------------------------------
// tb_mem_responder
// Directed-vector bench for mem_responder with hand-computed expectations.
// Inputs change 1 ns after a rising edge; outputs are sampled at that point.
// -----------------------------------------------------------------------------
module tb_mem_responder;

  localparam int DW = 16;
  localparam int AW = 9;

  logic          clk = 1'b0;
  logic          reset;
  logic [1:0]    mem_cmd;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] write_data;
  logic [DW-1:0] read_data;
  logic          mem_rdy;
  logic [7:0]    SW;
  logic [7:0]    LEDR;
  logic          err;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  mem_responder #(
    .DATA_W    (DW),
    .ADDR_W    (AW),
    .RAM_DEPTH (256)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .mem_cmd    (mem_cmd),
    .mem_addr   (mem_addr),
    .write_data (write_data),
    .read_data  (read_data),
    .mem_rdy    (mem_rdy),
    .SW         (SW),
    .LEDR       (LEDR),
    .err        (err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // One request: accept edge, check the RESP cycle, drop the command, check IDLE.
  task automatic xact(input string tag, input logic [1:0] cmd, input logic [AW-1:0] addr,
                      input logic [DW-1:0] wd, input logic [DW-1:0] exp_rd);
    mem_cmd    = cmd;
    mem_addr   = addr;
    write_data = wd;
    tick;
    check({tag, "_rdy_resp"}, mem_rdy, 1);
    if (cmd == 2'b01) check({tag, "_rd_resp"}, read_data, exp_rd);
    mem_cmd = 2'b00;
    tick;
    check({tag, "_rdy_idle"}, mem_rdy, 0);
    if (cmd == 2'b01) check({tag, "_rd_hold"}, read_data, exp_rd);
  endtask

  initial begin
    reset      = 1'b0;
    mem_cmd    = 2'b00;
    mem_addr   = 9'h000;
    write_data = 16'h0000;
    SW         = 8'h00;
    tick;
    tick;
    check("rst_rdy", mem_rdy, 0);
    check("rst_rd", read_data, 0);
    check("rst_led", LEDR, 0);
    check("rst_err", err, 0);
    reset = 1'b1;

    // Basic RAM write/read round trip.
    xact("wr005", 2'b10, 9'h005, 16'hBEEF, 16'h0000);
    xact("rd005", 2'b01, 9'h005, 16'h0000, 16'hBEEF);
    check("err_after_ram", err, 0);

    // Switch read, then switches change without disturbing held data.
    SW = 8'hA5;
    xact("rdsw", 2'b01, 9'h140, 16'h0000, 16'h00A5);
    check("err_after_sw", err, 0);
    SW = 8'h3C;
    tick;
    check("sw_hold", read_data, 16'h00A5);

    // Top RAM word.
    xact("wr0ff", 2'b10, 9'h0FF, 16'h5A5A, 16'h0000);
    xact("rd0ff", 2'b01, 9'h0FF, 16'h0000, 16'h5A5A);

    // LED write, then illegal read of the LED address.
    xact("wrled", 2'b10, 9'h100, 16'h1234, 16'h0000);
    check("led_val", LEDR, 8'h34);
    check("err_led_wr", err, 0);
    xact("rdled", 2'b01, 9'h100, 16'h0000, 16'h0000);
    check("err_led_rd", err, 1);
    tick;
    tick;
    tick;
    check("err_sticky", err, 1);

    // Unmapped 0x105 must not alias onto RAM word 0x005; SW is not writable.
    xact("wr105", 2'b10, 9'h105, 16'h1111, 16'h0000);
    xact("rd_alias", 2'b01, 9'h005, 16'h0000, 16'hBEEF);
    xact("wrsw", 2'b10, 9'h140, 16'h2222, 16'h0000);
    check("led_untouched", LEDR, 8'h34);

    // Async reset clears registers immediately.
    reset = 1'b0;
    #1;
    check("rst2_err", err, 0);
    check("rst2_led", LEDR, 0);
    check("rst2_rd", read_data, 0);
    tick;
    reset = 1'b1;

    // Illegal command: no completion, err set; RAM survived reset.
    mem_cmd = 2'b11;
    tick;
    check("ill_rdy", mem_rdy, 0);
    check("ill_err", err, 1);
    mem_cmd = 2'b00;
    xact("rd_keep", 2'b01, 9'h005, 16'h0000, 16'hBEEF);
    xact("rd1ff", 2'b01, 9'h1FF, 16'h0000, 16'h0000);

    // WRITE with READ of the same address presented during its RESP.
    mem_cmd    = 2'b10;
    mem_addr   = 9'h020;
    write_data = 16'h1357;
    tick;
    check("b2b_wr_rdy", mem_rdy, 1);
    mem_cmd = 2'b01;
    tick;
    check("b2b_gap_rdy", mem_rdy, 0);
    tick;
    check("b2b_rd_rdy", mem_rdy, 1);
    check("b2b_rd_data", read_data, 16'h1357);
    mem_cmd = 2'b00;
    tick;

    // READ held for four cycles: two accepts.
    mem_cmd  = 2'b01;
    mem_addr = 9'h0FF;
    check("hold_c0", mem_rdy, 0);
    tick;
    check("hold_c1", mem_rdy, 1);
    tick;
    check("hold_c2", mem_rdy, 0);
    tick;
    check("hold_c3", mem_rdy, 1);
    check("hold_data", read_data, 16'h5A5A);
    mem_cmd = 2'b00;
    tick;

    // Reset during a write's RESP; then a write whose edge falls inside reset.
    reset = 1'b0;
    tick;
    reset = 1'b1;
    xact("wrled2", 2'b10, 9'h100, 16'h0077, 16'h0000);
    check("led2_val", LEDR, 8'h77);
    mem_cmd    = 2'b10;
    mem_addr   = 9'h010;
    write_data = 16'hCAFE;
    tick;
    check("mid_rdy", mem_rdy, 1);
    mem_cmd = 2'b00;
    #2;
    reset = 1'b0;
    #1;
    check("mid_rst_rdy", mem_rdy, 0);
    check("mid_rst_led", LEDR, 0);
    check("mid_rst_err", err, 0);
    mem_cmd    = 2'b10;
    write_data = 16'hDEAD;
    tick;
    check("inrst_rdy", mem_rdy, 0);
    mem_cmd = 2'b00;
    reset   = 1'b1;
    xact("rd010", 2'b01, 9'h010, 16'h0000, 16'hCAFE);
    check("final_err", err, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_mem_responder
